// File: rtl/timer_pkg.sv
// Register map and bit positions shared by the
// multi-channel interval timer.
package timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAPSHOT = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_IRQSUM   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
  localparam int CTRL_EXT   = 4;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_channel.sv
// One interval timer channel: prescaler, down counter,
// run/timeout flags, snapshot and trigger edge detect.
module timer_channel
  import timer_pkg::*;
#(
  parameter int          COUNT_W    = 32,
  parameter int          PRESC_W    = 16,
  parameter int unsigned PERIOD_RST = 149999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [2:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic        trig,
  output logic [31:0] rdata,
  output logic        irq_bit,
  output logic        tick_out
);

  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] period;
  logic [COUNT_W-1:0] snap;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic run, to, ext, cont, ito, trig_q;

  logic wr_stat, wr_ctrl, wr_per, wr_snap, wr_presc;
  logic pre_tick, timeout, start, stop;
  logic unused_wdata;

  assign wr_stat  = we && (reg_sel == REG_STATUS);
  assign wr_ctrl  = we && (reg_sel == REG_CONTROL);
  assign wr_per   = we && (reg_sel == REG_PERIOD);
  assign wr_snap  = we && (reg_sel == REG_SNAPSHOT);
  assign wr_presc = we && (reg_sel == REG_PRESCALE);

  assign pre_tick = run && (pcnt == '0);
  assign timeout  = pre_tick && (cnt == '0);

  assign start = (wr_ctrl && wdata[CTRL_START])
               || (ext && trig && !trig_q);
  // START in the same write overrides STOP
  assign stop  = wr_ctrl && wdata[CTRL_STOP]
               && !wdata[CTRL_START];

  assign irq_bit      = to && ito;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= COUNT_W'(PERIOD_RST);
      period   <= COUNT_W'(PERIOD_RST);
      snap     <= '0;
      presc    <= '0;
      pcnt     <= '0;
      run      <= 1'b0;
      to       <= 1'b0;
      ext      <= 1'b0;
      cont     <= 1'b0;
      ito      <= 1'b0;
      trig_q   <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      trig_q   <= trig;
      tick_out <= timeout;
      if (wr_per) begin
        period <= wdata[COUNT_W-1:0];
        cnt    <= wdata[COUNT_W-1:0];
        pcnt   <= presc;
        run    <= 1'b0;
      end else if (start && !run) begin
        cnt  <= period;
        pcnt <= presc;
        run  <= 1'b1;
      end else begin
        if (run)
          pcnt <= (pcnt == '0) ? presc : pcnt - 1'b1;
        if (pre_tick)
          cnt <= (cnt == '0) ? period : cnt - 1'b1;
        if (stop || (timeout && !cont))
          run <= 1'b0;
      end
      // a timeout beats a coincident clear
      if (timeout)
        to <= 1'b1;
      else if (wr_stat)
        to <= 1'b0;
      if (wr_ctrl) begin
        ext  <= wdata[CTRL_EXT];
        cont <= wdata[CTRL_CONT];
        ito  <= wdata[CTRL_ITO];
      end
      if (wr_presc)
        presc <= wdata[PRESC_W-1:0];
      if (wr_snap)
        snap <= cnt;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[STAT_RUN] = run;
        rdata[STAT_TO]  = to;
      end
      REG_CONTROL: begin
        rdata[CTRL_EXT]  = ext;
        rdata[CTRL_CONT] = cont;
        rdata[CTRL_ITO]  = ito;
      end
      REG_PERIOD:   rdata = 32'(period);
      REG_SNAPSHOT: rdata = 32'(snap);
      REG_PRESCALE: rdata = 32'(presc);
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/avmm_multi_interval_timer.sv
// Avalon-MM slave wrapping NUM_CH interval timers:
// address decode, registered read mux and irq OR.
module avmm_multi_interval_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          COUNT_W    = 32,
  parameter int          PRESC_W    = 16,
  parameter int unsigned PERIOD_RST = 149999,
  localparam int         AW         = 3 + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] trig_in,
  output logic [NUM_CH-1:0] tick_out,
  output logic              irq
);

  logic [AW-1:0]     ch;
  logic [2:0]        reg_sel;
  logic [31:0]       rd [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;
  logic [31:0]       rd_mux;

  assign ch      = address >> 3;
  assign reg_sel = address[2:0];
  assign irq     = |irq_vec;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we;
    assign we = chipselect && !write_n && (ch == AW'(g));

    timer_channel #(
      .COUNT_W    (COUNT_W),
      .PRESC_W    (PRESC_W),
      .PERIOD_RST (PERIOD_RST)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .reg_sel  (reg_sel),
      .wdata    (writedata),
      .trig     (trig_in[g]),
      .rdata    (rd[g]),
      .irq_bit  (irq_vec[g]),
      .tick_out (tick_out[g])
    );
  end

  // out-of-range channels fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == AW'(i))
        rd_mux = (reg_sel == REG_IRQSUM) ? 32'(irq_vec) : rd[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_mux;
  end

endmodule

// File: tb/tb_avmm_multi_interval_timer.sv
// Directed bench for the multi-channel interval timer.
module tb_avmm_multi_interval_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  trig_in = '0;
  logic [3:0]  tick_out;
  logic        irq;

  int nvec = 0;
  int nerr = 0;

  avmm_multi_interval_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .trig_in    (trig_in),
    .tick_out   (tick_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input int c, input int r,
                        input logic [31:0] d);
    @(negedge clk);
    address    = 5'(c * 8 + r);
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input int c, input int r,
                        output logic [31:0] d);
    @(negedge clk);
    address    = 5'(c * 8 + r);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_tick(input int c, input int max,
                           output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick_out[c] && k < max);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    if (readdata !== 32'd0 || tick_out !== 4'd0 || irq !== 1'b0) begin
      $display("FAIL reset_outs got rd=%0h tick=%0b irq=%0b want 0",
               readdata, tick_out, irq);
      nerr++;
    end
    nvec++;
    bus_rd(0, 2, d);
    if (d !== 32'd149999) begin
      $display("FAIL reset_period got %0d want 149999", d); nerr++;
    end
    nvec++;
    bus_rd(0, 0, d);
    if (d !== 32'd0) begin
      $display("FAIL reset_status got %0h want 0", d); nerr++;
    end
    nvec++;
    bus_rd(0, 4, d);
    if (d !== 32'd0) begin
      $display("FAIL reset_prescale got %0h want 0", d); nerr++;
    end
    nvec++;
    bus_rd(0, 6, d);
    if (d !== 32'd0) begin
      $display("FAIL reg6_zero got %0h want 0", d); nerr++;
    end
    nvec++;
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    int k;
    bus_wr(0, 2, 32'd9);
    bus_wr(0, 1, 32'h6);
    wait_tick(0, 40, k);
    if (k !== 10) begin
      $display("FAIL cont_first got %0d clks want 10", k); nerr++;
    end
    nvec++;
    wait_tick(0, 40, k);
    if (k !== 10) begin
      $display("FAIL cont_second got %0d clks want 10", k); nerr++;
    end
    nvec++;
    bus_rd(0, 0, d);
    if (d !== 32'd3) begin
      $display("FAIL cont_status got %0h want 3", d); nerr++;
    end
    nvec++;
    bus_wr(0, 1, 32'h8);
    bus_rd(0, 0, d);
    if (d !== 32'd1) begin
      $display("FAIL stop_status got %0h want 1", d); nerr++;
    end
    nvec++;
    bus_wr(0, 0, 32'h0);
    bus_rd(0, 0, d);
    if (d !== 32'd0) begin
      $display("FAIL clear_status got %0h want 0", d); nerr++;
    end
    nvec++;
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int k;
    bus_wr(1, 2, 32'd4);
    bus_wr(1, 4, 32'd2);
    bus_wr(1, 1, 32'h5);
    wait_tick(1, 60, k);
    if (k !== 15) begin
      $display("FAIL oneshot_len got %0d clks want 15", k); nerr++;
    end
    nvec++;
    if (irq !== 1'b1) begin
      $display("FAIL oneshot_irq got %0b want 1", irq); nerr++;
    end
    nvec++;
    bus_rd(1, 0, d);
    if (d !== 32'd1) begin
      $display("FAIL oneshot_status got %0h want 1", d); nerr++;
    end
    nvec++;
    bus_rd(1, 1, d);
    if (d !== 32'd1) begin
      $display("FAIL oneshot_ctrl got %0h want 1", d); nerr++;
    end
    nvec++;
    bus_rd(3, 5, d);
    if (d !== 32'd2) begin
      $display("FAIL irq_summary got %0h want 2", d); nerr++;
    end
    nvec++;
    wait_tick(1, 25, k);
    if (k !== 25 || tick_out[1] !== 1'b0) begin
      $display("FAIL oneshot_rerun got tick after %0d want none", k);
      nerr++;
    end
    nvec++;
    bus_wr(1, 0, 32'hffff_ffff);
    if (irq !== 1'b0) begin
      $display("FAIL irq_clear got %0b want 0", irq); nerr++;
    end
    nvec++;
  endtask

  task automatic test_trigger();
    logic [31:0] d;
    bus_wr(2, 2, 32'd50);
    bus_wr(2, 1, 32'h10);
    bus_wr(3, 1, 32'h10);
    @(negedge clk); trig_in = 4'b0100;
    @(negedge clk); trig_in = 4'b0000;
    @(negedge clk); trig_in = 4'b0100;
    @(negedge clk); trig_in = 4'b0000;
    bus_wr(2, 3, 32'h0);
    bus_rd(2, 3, d);
    if (d !== 32'd47) begin
      $display("FAIL trig_noreload got %0d want 47", d); nerr++;
    end
    nvec++;
    bus_rd(2, 0, d);
    if (d !== 32'd2) begin
      $display("FAIL trig_ch2_run got %0h want 2", d); nerr++;
    end
    nvec++;
    bus_rd(3, 0, d);
    if (d !== 32'd0) begin
      $display("FAIL trig_ch3_idle got %0h want 0", d); nerr++;
    end
    nvec++;
    bus_wr(2, 1, 32'h8);
  endtask

  task automatic test_period_write();
    logic [31:0] d;
    bus_wr(1, 2, 32'd1000);
    bus_wr(1, 1, 32'h6);
    repeat (5) @(negedge clk);
    bus_wr(1, 2, 32'd100);
    bus_rd(1, 0, d);
    if (d !== 32'd0) begin
      $display("FAIL perwr_status got %0h want 0", d); nerr++;
    end
    nvec++;
    repeat (3) @(negedge clk);
    bus_wr(1, 3, 32'h0);
    bus_rd(1, 3, d);
    if (d !== 32'd100) begin
      $display("FAIL perwr_snap got %0d want 100", d); nerr++;
    end
    nvec++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_wr(0, 1, 32'h6);
    repeat (8) @(negedge clk);
    bus_wr(0, 0, 32'h0);
    if (tick_out[0] !== 1'b1) begin
      $display("FAIL b2b_tick got %0b want 1", tick_out[0]); nerr++;
    end
    nvec++;
    bus_rd(0, 0, d);
    if (d !== 32'd3) begin
      $display("FAIL b2b_to_kept got %0h want 3", d); nerr++;
    end
    nvec++;
    bus_wr(0, 1, 32'h8);
    bus_wr(0, 1, 32'hE);
    bus_rd(0, 0, d);
    if (d[1] !== 1'b1) begin
      $display("FAIL start_stop got run=%0b want 1", d[1]); nerr++;
    end
    nvec++;
    bus_wr(0, 1, 32'h8);
  endtask

  task automatic test_every_clk_reset();
    logic [31:0] d;
    bus_wr(3, 2, 32'd0);
    bus_wr(3, 1, 32'h7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tick_out[3] !== 1'b1) begin
        $display("FAIL every_clk_%0d got %0b want 1", i, tick_out[3]);
        nerr++;
      end
      nvec++;
    end
    bus_rd(3, 1, d);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    if (tick_out !== 4'd0 || irq !== 1'b0 || readdata !== 32'd0) begin
      $display("FAIL async_reset got tick=%0b irq=%0b rd=%0h want 0",
               tick_out, irq, readdata);
      nerr++;
    end
    nvec++;
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(3, 3, d);
    if (d !== 32'd0) begin
      $display("FAIL snap_after_rst got %0d want 0", d); nerr++;
    end
    nvec++;
    bus_wr(3, 3, 32'h0);
    bus_rd(3, 3, d);
    if (d !== 32'd149999) begin
      $display("FAIL cnt_after_rst got %0d want 149999", d); nerr++;
    end
    nvec++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_continuous();
    test_oneshot();
    test_trigger();
    test_period_write();
    test_back_to_back();
    test_every_clk_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
